// File: rtl/subservient_uart_loader.sv
// -----------------------------------------------------------------------------
// subservient_uart_loader
//
// UART boot loader for subservient_core. It receives an 8N1 byte stream, builds
// little-endian 32-bit words from it and writes each word through the core's
// debug Wishbone port. The core is held in debug mode until the whole image has
// been written.
//
// Frame: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes with the
// least significant byte of each word first.
//
// Optional build macro: SUBSERVIENT_UART_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the image. It must equal the XOR of
//   both length bytes and every data byte. A match releases the core. A
//   mismatch sets o_error and parks the loader in a terminal error state with
//   the core still held in debug mode.
//
// Ports:
//   i_clk          clock
//   i_rst          asynchronous active-high reset
//   i_uart_rx      serial input, idle high, asynchronous to i_clk
//   o_debug_mode   high while loading (to core i_debug_mode)
//   o_wb_dbg_adr   write byte address
//   o_wb_dbg_dat   write data
//   o_wb_dbg_sel   byte select, always 4'hf
//   o_wb_dbg_we    write enable, always 1
//   o_wb_dbg_stb   write request, held until i_wb_dbg_ack
//   i_wb_dbg_ack   write acknowledge
//   o_done         image loaded, core released
//   o_error        sticky error flag (framing, overrun, checksum)
// -----------------------------------------------------------------------------
module subservient_uart_loader #(
   parameter int          CLKS_PER_BIT = 139,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_uart_rx,
   output logic        o_debug_mode,
   output logic [31:0] o_wb_dbg_adr,
   output logic [31:0] o_wb_dbg_dat,
   output logic [3:0]  o_wb_dbg_sel,
   output logic        o_wb_dbg_we,
   output logic        o_wb_dbg_stb,
   input  logic        i_wb_dbg_ack,
   output logic        o_done,
   output logic        o_error
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   // ---------------------------------------------------------------- UART RX
   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;  // after a framing error

   logic          rx_meta, rx_sync, rx_prev;
   logic [2:0]    rx_state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift;
   logic          rx_valid;
   logic          frame_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= RX_IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= i_uart_rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               if (rx_prev && !rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt == HALF_CNT) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  // Line back high at mid-start: treat as a glitch.
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt  <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) rx_state <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (clk_cnt == FULL_CNT) begin
                  clk_cnt <= '0;
                  if (rx_sync) begin
                     rx_valid <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rx_state  <= RX_WAIT;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               if (rx_sync) rx_state <= RX_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------- loader FSM
   localparam logic [2:0] LD_LEN_LO = 3'd0;
   localparam logic [2:0] LD_LEN_HI = 3'd1;
   localparam logic [2:0] LD_DATA   = 3'd2;
   localparam logic [2:0] LD_WRITE  = 3'd3;
   localparam logic [2:0] LD_DONE   = 3'd4;
   localparam logic [2:0] LD_CSUM   = 3'd5;
   localparam logic [2:0] LD_ERR    = 3'd6;

`ifdef SUBSERVIENT_UART_LOADER_CHECKSUM_EN
   localparam logic [2:0] LD_FINISH = LD_CSUM;
`else
   localparam logic [2:0] LD_FINISH = LD_DONE;
`endif

   logic [2:0]  ld_state;
   logic [15:0] len;
   logic [15:0] word_cnt;
   logic [1:0]  byte_idx;
   logic [23:0] word_asm;   // lower three bytes of the word being assembled
   logic [7:0]  csum;
   logic        word_done;
   logic        last_word;

   assign word_done = rx_valid && (byte_idx == 2'd3);
   assign last_word = (16'(word_cnt + 16'd1) == len);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ld_state     <= LD_LEN_LO;
         len          <= '0;
         word_cnt     <= '0;
         byte_idx     <= '0;
         word_asm     <= '0;
         csum         <= '0;
         o_wb_dbg_adr <= BASE_ADDR;
         o_wb_dbg_dat <= '0;
         o_wb_dbg_stb <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         if (frame_err) o_error <= 1'b1;
         if (rx_valid && (ld_state <= LD_WRITE)) csum <= csum ^ rx_shift;
         case (ld_state)
            LD_LEN_LO: begin
               if (rx_valid) begin
                  len[7:0] <= rx_shift;
                  ld_state <= LD_LEN_HI;
               end
            end
            LD_LEN_HI: begin
               if (rx_valid) begin
                  len[15:8] <= rx_shift;
                  byte_idx  <= '0;
                  word_cnt  <= '0;
                  ld_state  <= ({rx_shift, len[7:0]} == 16'd0) ? LD_FINISH : LD_DATA;
               end
            end
            LD_DATA: begin
               if (rx_valid) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (word_done) begin
                     o_wb_dbg_dat <= {rx_shift, word_asm};
                     o_wb_dbg_stb <= 1'b1;
                     ld_state     <= LD_WRITE;
                  end else begin
                     word_asm[8*byte_idx +: 8] <= rx_shift;
                  end
               end
            end
            LD_WRITE: begin
               // Keep assembling the next word while the write is pending.
               if (rx_valid) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (!word_done) word_asm[8*byte_idx +: 8] <= rx_shift;
               end
               if (i_wb_dbg_ack) begin
                  o_wb_dbg_stb <= 1'b0;
                  o_wb_dbg_adr <= o_wb_dbg_adr + 32'd4;
                  word_cnt     <= word_cnt + 16'd1;
                  if (last_word) begin
                     ld_state <= LD_FINISH;
                  end else if (word_done) begin
                     // Next word completed on the ack cycle: launch it directly.
                     o_wb_dbg_dat <= {rx_shift, word_asm};
                     o_wb_dbg_stb <= 1'b1;
                  end else begin
                     ld_state <= LD_DATA;
                  end
               end else if (word_done) begin
                  // Overrun: previous write still pending, drop this word.
                  o_error <= 1'b1;
               end
            end
            LD_CSUM: begin
               if (rx_valid) begin
                  if (rx_shift == csum) begin
                     ld_state <= LD_DONE;
                  end else begin
                     o_error  <= 1'b1;
                     ld_state <= LD_ERR;
                  end
               end
            end
            default: ;  // LD_DONE / LD_ERR are terminal until reset
         endcase
      end
   end

   assign o_done       = (ld_state == LD_DONE);
   assign o_debug_mode = !o_done;
   assign o_wb_dbg_sel = 4'hf;
   assign o_wb_dbg_we  = 1'b1;

endmodule
